// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
package bus_arbiter_pkg;

    localparam int StopAllBus  = 6;
    localparam int StallIfBit  = 1;
    localparam int StallMemBit = 4;

    typedef logic [31:0] register_t;
    typedef logic [7:0]  bus_timeout_t;

    localparam register_t ZeroWord    = 32'h0000_0000;
    localparam logic      Stop        = 1'b1;
    localparam logic      NoStop      = 1'b0;
    localparam logic      ResetEnable = 1'b1;

    typedef enum logic [1:0] {
        BUS_IDLE     = 2'b00,
        BUS_BUSY_MEM = 2'b01,
        BUS_BUSY_IF  = 2'b10,
        BUS_DRAIN    = 2'b11
    } bus_state_e;

    // Payload of one master-side transaction, held for the whole cycle.
    typedef struct packed {
        logic      we;
        logic [3:0] sel;
        register_t addr;
        register_t data;
    } bus_req_t;

    localparam bus_req_t BusReqIdle = '0;

    // Instruction fetches are always full-word reads.
    function automatic bus_req_t make_fetch(input register_t addr);
        bus_req_t r;
        r.we   = 1'b0;
        r.sel  = 4'b1111;
        r.addr = addr;
        r.data = ZeroWord;
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Bus watchdog: counts cycles of an unacknowledged transaction and flags
// expiry once the count reaches TIMEOUT_CYCLES - 1.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    bus_timeout_t count;

    assign expired = (count == bus_timeout_t'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero while cleared and saturates at the expiry value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset == ResetEnable) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + bus_timeout_t'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter sharing the single Wishbone-style memory port between IF and MEM.
// One transaction at a time, MEM has fixed priority, a flushed transaction
// is drained to its ack, and a watchdog converts a lost ack into a bus error.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [StopAllBus-1:0] stop_all,
    input  logic                  flush,

    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic [31:0]           if_rdata,
    output logic                  stop_req_from_if,

    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [3:0]            mem_sel,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  stop_req_from_mem,

    output logic                  bus_cyc_o,
    output logic                  bus_stb_o,
    output logic                  bus_we_o,
    output logic [3:0]            bus_sel_o,
    output logic [31:0]           bus_addr_o,
    output logic [31:0]           bus_data_o,
    input  logic [31:0]           bus_data_i,
    input  logic                  bus_ack_i,
    output logic                  bus_error
);

    bus_state_e state;
    bus_req_t   bus_q;
    logic       bus_cyc_q;
    logic       bus_stb_q;
    register_t  if_buf;
    register_t  mem_buf;
    logic       done_if;
    logic       done_mem;
    logic       wd_expired;
    logic       unused_stall_bits;

    assign unused_stall_bits = ^{stop_all[5], stop_all[3:2], stop_all[0]};

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == BUS_IDLE),
        .enable ((state != BUS_IDLE) && !bus_ack_i),
        .expired(wd_expired)
    );

    assign bus_cyc_o  = bus_cyc_q;
    assign bus_stb_o  = bus_stb_q;
    assign bus_we_o   = bus_q.we;
    assign bus_sel_o  = bus_q.sel;
    assign bus_addr_o = bus_q.addr;
    assign bus_data_o = bus_q.data;

    assign if_rdata  = if_buf;
    assign mem_rdata = mem_buf;

    assign stop_req_from_if  = (reset == ResetEnable) ? NoStop :
                               ((if_req && !done_if && !flush) ? Stop : NoStop);
    assign stop_req_from_mem = (reset == ResetEnable) ? NoStop :
                               ((mem_req && !done_mem && !flush) ? Stop : NoStop);

    // Arbitration FSM; a completion setting done wins over the stage-advance clear,
    // and a flush overrides both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset == ResetEnable) begin
            state     <= BUS_IDLE;
            bus_q     <= BusReqIdle;
            bus_cyc_q <= 1'b0;
            bus_stb_q <= 1'b0;
            if_buf    <= ZeroWord;
            mem_buf   <= ZeroWord;
            done_if   <= 1'b0;
            done_mem  <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= 1'b0;

            if (flush) begin
                done_if  <= 1'b0;
                done_mem <= 1'b0;
            end else begin
                if (!stop_all[StallIfBit]) begin
                    done_if <= 1'b0;
                end
                if (!stop_all[StallMemBit]) begin
                    done_mem <= 1'b0;
                end
            end

            case (state)
                BUS_IDLE: begin
                    if (mem_req && !done_mem && !flush) begin
                        state     <= BUS_BUSY_MEM;
                        bus_cyc_q <= 1'b1;
                        bus_stb_q <= 1'b1;
                        bus_q.we   <= mem_we;
                        bus_q.sel  <= mem_sel;
                        bus_q.addr <= mem_addr;
                        bus_q.data <= mem_wdata;
                    end else if (if_req && !done_if && !flush) begin
                        state     <= BUS_BUSY_IF;
                        bus_cyc_q <= 1'b1;
                        bus_stb_q <= 1'b1;
                        bus_q     <= make_fetch(if_addr);
                    end
                end

                BUS_BUSY_MEM, BUS_BUSY_IF: begin
                    if (bus_ack_i || wd_expired) begin
                        state     <= BUS_IDLE;
                        bus_cyc_q <= 1'b0;
                        bus_stb_q <= 1'b0;
                        bus_q     <= BusReqIdle;
                        bus_error <= !bus_ack_i;
                        if (!flush) begin
                            if (state == BUS_BUSY_MEM) begin
                                mem_buf  <= bus_ack_i ? bus_data_i : ZeroWord;
                                done_mem <= 1'b1;
                            end else begin
                                if_buf  <= bus_ack_i ? bus_data_i : ZeroWord;
                                done_if <= 1'b1;
                            end
                        end
                    end else if (flush) begin
                        state <= BUS_DRAIN;
                    end
                end

                BUS_DRAIN: begin
                    if (bus_ack_i || wd_expired) begin
                        state     <= BUS_IDLE;
                        bus_cyc_q <= 1'b0;
                        bus_stb_q <= 1'b0;
                        bus_q     <= BusReqIdle;
                        bus_error <= !bus_ack_i;
                    end
                end

                default: begin
                    state <= BUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter with a scoreboard of bus transactions.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  stop_all;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        stop_req_from_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stop_req_from_mem;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        bus_error;

    int tests = 0;
    int fails = 0;

    bus_req_t sb[$];
    bus_req_t exp_txn;
    logic     cyc_prev = 1'b0;
    int       stb_cnt = 0;
    int       ack_delay = 1;
    logic     slave_en = 1'b1;

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .stop_all         (stop_all),
        .flush            (flush),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_rdata         (if_rdata),
        .stop_req_from_if (stop_req_from_if),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_sel          (mem_sel),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .stop_req_from_mem(stop_req_from_mem),
        .bus_cyc_o        (bus_cyc_o),
        .bus_stb_o        (bus_stb_o),
        .bus_we_o         (bus_we_o),
        .bus_sel_o        (bus_sel_o),
        .bus_addr_o       (bus_addr_o),
        .bus_data_o       (bus_data_o),
        .bus_data_i       (bus_data_i),
        .bus_ack_i        (bus_ack_i),
        .bus_error        (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return a ^ 32'hCAFE_F00D;
    endfunction

    assign bus_data_i = slave_word(bus_addr_o);

    // Slave: acks in the ack_delay-th cycle that stb has been seen high.
    always @(posedge clk) begin
        #2;
        if (bus_cyc_o && bus_stb_o && slave_en) begin
            stb_cnt   = stb_cnt + 1;
            bus_ack_i = (stb_cnt >= ack_delay);
        end else begin
            stb_cnt   = 0;
            bus_ack_i = 1'b0;
        end
    end

    // Scoreboard: every new bus cycle must match the oldest expected transaction.
    always @(posedge clk) begin
        #2;
        if (bus_cyc_o === 1'b1 && cyc_prev === 1'b0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL sb_unexpected: bus cycle to %h, expected no transaction", bus_addr_o);
            end else begin
                exp_txn = sb.pop_front();
                if ({bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== exp_txn) begin
                    fails++;
                    $display("[TB] FAIL sb_txn: got we=%b sel=%b addr=%h data=%h, expected we=%b sel=%b addr=%h data=%h",
                             bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
                             exp_txn.we, exp_txn.sel, exp_txn.addr, exp_txn.data);
                end
            end
        end
        cyc_prev = bus_cyc_o;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
        bus_req_t t;
        t.we = we; t.sel = sel; t.addr = addr; t.data = data;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_cyc: got %b expected 0", bus_cyc_o); end
        tests++; if ({bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== 70'd0) begin fails++;
            $display("[TB] FAIL reset_bus: got stb=%b we=%b sel=%b addr=%h data=%h expected all 0", bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o); end
        tests++; if ({if_rdata, mem_rdata} !== 64'd0) begin fails++; $display("[TB] FAIL reset_bufs: got %h %h expected 0", if_rdata, mem_rdata); end
        tests++; if (bus_error !== 1'b0) begin fails++; $display("[TB] FAIL reset_error: got %b expected 0", bus_error); end
        if_req = 1'b1; mem_req = 1'b1;
        #1;
        tests++; if ({stop_req_from_if, stop_req_from_mem} !== 2'b00) begin fails++;
            $display("[TB] FAIL reset_stops: got %b expected 00", {stop_req_from_if, stop_req_from_mem}); end
        if_req = 1'b0; mem_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_release_cyc: got %b expected 0", bus_cyc_o); end
    endtask

    task automatic test_if_read();
        stop_all = 6'b000010; ack_delay = 1;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        push_txn(1'b0, 4'b1111, 32'h0000_0100, 32'h0);
        #1;
        tests++; if (stop_req_from_if !== 1'b1) begin fails++; $display("[TB] FAIL if_stop_c0: got %b expected 1", stop_req_from_if); end
        tick();
        tests++; if (bus_cyc_o !== 1'b1 || bus_stb_o !== 1'b1) begin fails++; $display("[TB] FAIL if_bus_up: got cyc=%b stb=%b expected 1 1", bus_cyc_o, bus_stb_o); end
        tests++; if (stop_req_from_if !== 1'b1) begin fails++; $display("[TB] FAIL if_stop_c1: got %b expected 1", stop_req_from_if); end
        tick();
        tests++; if (stop_req_from_if !== 1'b0) begin fails++; $display("[TB] FAIL if_stop_done: got %b expected 0", stop_req_from_if); end
        tests++; if (if_rdata !== slave_word(32'h0000_0100)) begin fails++; $display("[TB] FAIL if_rdata: got %h expected %h", if_rdata, slave_word(32'h0000_0100)); end
        tests++; if (bus_cyc_o !== 1'b0 || bus_addr_o !== 32'h0) begin fails++; $display("[TB] FAIL if_bus_idle: got cyc=%b addr=%h expected 0 0", bus_cyc_o, bus_addr_o); end
        if_req = 1'b0; stop_all = 6'b000000;
        tick();
        tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL if_after: got %b expected 0", bus_cyc_o); end
    endtask

    task automatic test_back_to_back();
        stop_all = 6'b010010; ack_delay = 1;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h0000_0080; mem_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        push_txn(1'b1, 4'b0011, 32'h0000_0080, 32'hDEAD_BEEF);
        push_txn(1'b0, 4'b1111, 32'h0000_0200, 32'h0);
        tick();
        tests++; if (bus_we_o !== 1'b1 || bus_sel_o !== 4'b0011 || bus_addr_o !== 32'h80) begin fails++;
            $display("[TB] FAIL b2b_mem_first: got we=%b sel=%b addr=%h expected 1 0011 00000080", bus_we_o, bus_sel_o, bus_addr_o); end
        tests++; if ({stop_req_from_if, stop_req_from_mem} !== 2'b11) begin fails++; $display("[TB] FAIL b2b_stops_c1: got %b expected 11", {stop_req_from_if, stop_req_from_mem}); end
        tick();
        tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL b2b_idle_gap: got cyc=%b expected 0", bus_cyc_o); end
        tests++; if ({stop_req_from_if, stop_req_from_mem} !== 2'b10) begin fails++; $display("[TB] FAIL b2b_stops_c2: got %b expected 10", {stop_req_from_if, stop_req_from_mem}); end
        mem_req = 1'b0; mem_we = 1'b0; stop_all = 6'b000010;
        tick();
        tests++; if (bus_cyc_o !== 1'b1 || bus_we_o !== 1'b0 || bus_sel_o !== 4'b1111 || bus_addr_o !== 32'h200) begin fails++;
            $display("[TB] FAIL b2b_if_second: got cyc=%b we=%b sel=%b addr=%h expected 1 0 1111 00000200", bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o); end
        tests++; if (stop_req_from_if !== 1'b1) begin fails++; $display("[TB] FAIL b2b_if_stop_held: got %b expected 1", stop_req_from_if); end
        tick();
        tests++; if (if_rdata !== slave_word(32'h200)) begin fails++; $display("[TB] FAIL b2b_if_rdata: got %h expected %h", if_rdata, slave_word(32'h200)); end
        tests++; if (stop_req_from_if !== 1'b0) begin fails++; $display("[TB] FAIL b2b_if_release: got %b expected 0", stop_req_from_if); end
        if_req = 1'b0; stop_all = 6'b000000;
        tick();
    endtask

    task automatic test_load_hold();
        stop_all = 6'b011111; ack_delay = 1;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_0300; mem_wdata = 32'h0;
        push_txn(1'b0, 4'b1111, 32'h0000_0300, 32'h0);
        tick();
        tick();
        tests++; if (mem_rdata !== slave_word(32'h300)) begin fails++; $display("[TB] FAIL hold_rdata: got %h expected %h", mem_rdata, slave_word(32'h300)); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus_cyc_o !== 1'b0 || stop_req_from_mem !== 1'b0 || mem_rdata !== slave_word(32'h300)) begin fails++;
                $display("[TB] FAIL hold_cycle%0d: got cyc=%b stop=%b rdata=%h expected 0 0 %h", i, bus_cyc_o, stop_req_from_mem, mem_rdata, slave_word(32'h300)); end
        end
        stop_all = 6'b000000;
        tick();
        tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL hold_release_cyc: got %b expected 0", bus_cyc_o); end
        mem_req = 1'b0;
        tick();
        tests++; if (mem_rdata !== slave_word(32'h300)) begin fails++; $display("[TB] FAIL hold_after: got %h expected %h", mem_rdata, slave_word(32'h300)); end
    endtask

    task automatic test_flush_drain();
        stop_all = 6'b000010; ack_delay = 5;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        push_txn(1'b0, 4'b1111, 32'h0000_0400, 32'h0);
        tick();
        flush = 1'b1; mem_req = 1'b1; mem_addr = 32'h0000_0900;
        #1;
        tests++; if ({stop_req_from_if, stop_req_from_mem} !== 2'b00) begin fails++; $display("[TB] FAIL flush_stops: got %b expected 00", {stop_req_from_if, stop_req_from_mem}); end
        tick();
        flush = 1'b0; mem_req = 1'b0; if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus_cyc_o !== 1'b1) begin fails++; $display("[TB] FAIL flush_drain_cyc%0d: got %b expected 1", i, bus_cyc_o); end
            tick();
        end
        tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL flush_drain_end: got %b expected 0", bus_cyc_o); end
        tests++; if (if_rdata !== slave_word(32'h200)) begin fails++; $display("[TB] FAIL flush_rdata_kept: got %h expected %h", if_rdata, slave_word(32'h200)); end
        tests++; if (bus_error !== 1'b0) begin fails++; $display("[TB] FAIL flush_no_error: got %b expected 0", bus_error); end
        if_req = 1'b1;
        #1;
        tests++; if (stop_req_from_if !== 1'b1) begin fails++; $display("[TB] FAIL flush_done_clear: got stop=%b expected 1", stop_req_from_if); end
        if_req = 1'b0; stop_all = 6'b000000; ack_delay = 1;
        tick();
    endtask

    task automatic test_ack_with_flush();
        stop_all = 6'b010000; ack_delay = 1;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_0500;
        push_txn(1'b0, 4'b1111, 32'h0000_0500, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL ackflush_cyc: got %b expected 0", bus_cyc_o); end
        tests++; if (mem_rdata !== slave_word(32'h300)) begin fails++; $display("[TB] FAIL ackflush_rdata: got %h expected %h", mem_rdata, slave_word(32'h300)); end
        flush = 1'b0;
        #1;
        tests++; if (stop_req_from_mem !== 1'b1) begin fails++; $display("[TB] FAIL ackflush_not_done: got stop=%b expected 1", stop_req_from_mem); end
        mem_req = 1'b0; stop_all = 6'b000000;
        tick();
    endtask

    task automatic test_timeout();
        stop_all = 6'b010000; slave_en = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_0600;
        push_txn(1'b0, 4'b1111, 32'h0000_0600, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin
            tests++; if (bus_cyc_o !== 1'b1 || bus_error !== 1'b0) begin fails++;
                $display("[TB] FAIL wd_wait%0d: got cyc=%b err=%b expected 1 0", i, bus_cyc_o, bus_error); end
            tick();
        end
        tests++; if (bus_cyc_o !== 1'b1) begin fails++; $display("[TB] FAIL wd_last: got cyc=%b expected 1", bus_cyc_o); end
        tick();
        tests++; if (bus_cyc_o !== 1'b0 || bus_error !== 1'b1) begin fails++; $display("[TB] FAIL wd_abort: got cyc=%b err=%b expected 0 1", bus_cyc_o, bus_error); end
        tests++; if (mem_rdata !== 32'h0) begin fails++; $display("[TB] FAIL wd_rdata: got %h expected 00000000", mem_rdata); end
        tests++; if (stop_req_from_mem !== 1'b0) begin fails++; $display("[TB] FAIL wd_release: got stop=%b expected 0", stop_req_from_mem); end
        mem_req = 1'b0; stop_all = 6'b000000; slave_en = 1'b1;
        tick();
        tests++; if (bus_error !== 1'b0) begin fails++; $display("[TB] FAIL wd_pulse_once: got err=%b expected 0", bus_error); end
        tick();
    endtask

    task automatic test_reset_mid();
        stop_all = 6'b010000; ack_delay = 6;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b1111; mem_addr = 32'h0000_0700; mem_wdata = 32'h1234_5678;
        push_txn(1'b1, 4'b1111, 32'h0000_0700, 32'h1234_5678);
        tick();
        tests++; if (bus_cyc_o !== 1'b1) begin fails++; $display("[TB] FAIL rmid_started: got %b expected 1", bus_cyc_o); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== 71'd0) begin fails++;
            $display("[TB] FAIL rmid_bus_drop: got cyc=%b stb=%b we=%b sel=%b addr=%h data=%h expected all 0", bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o); end
        tests++; if (if_rdata !== 32'h0 || stop_req_from_mem !== 1'b0) begin fails++; $display("[TB] FAIL rmid_state: got if_rdata=%h stop=%b expected 0 0", if_rdata, stop_req_from_mem); end
        mem_we = 1'b0; mem_addr = 32'h0000_0800; mem_wdata = 32'h0; ack_delay = 1;
        tick();
        reset = 1'b0;
        push_txn(1'b0, 4'b1111, 32'h0000_0800, 32'h0);
        tick();
        tests++; if (bus_cyc_o !== 1'b1 || bus_addr_o !== 32'h800) begin fails++; $display("[TB] FAIL rmid_rearb: got cyc=%b addr=%h expected 1 00000800", bus_cyc_o, bus_addr_o); end
        tick();
        tests++; if (mem_rdata !== slave_word(32'h800)) begin fails++; $display("[TB] FAIL rmid_rdata: got %h expected %h", mem_rdata, slave_word(32'h800)); end
        mem_req = 1'b0; stop_all = 6'b000000;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; stop_all = 6'b0; flush = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_ack_i = 1'b0;
        tick(); tick();
        test_reset();
        test_if_read();
        test_back_to_back();
        test_load_hold();
        test_flush_drain();
        test_ack_with_flush();
        test_timeout();
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin fails++; $display("[TB] FAIL sb_leftover: got %0d pending transactions expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
